// File: rtl/adc_sample_averager.sv
// Block averager for signed ADC samples on AXI Stream. It sums 2^k accepted samples,
// then emits the floor-shifted mean, sign-extended to 32 bits. k = 0 passes samples through.
module adc_sample_averager #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int MAX_LOG2_AVG = 8
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  log2_avg,
    input  logic        clear,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] status
);

    localparam int         ACC_W     = SAMPLE_WIDTH + MAX_LOG2_AVG;
    localparam logic [3:0] MAX_SHIFT = 4'(MAX_LOG2_AVG);

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [15:0]             count_q, count_d;
    logic [3:0]              shift_q, shift_d;
    logic [31:0]             mdata_q, mdata_d;
    logic                    mvalid_q, mvalid_d;

    logic signed [SAMPLE_WIDTH-1:0] sample;
    logic signed [ACC_W-1:0]        sample_ext;
    logic signed [ACC_W-1:0]        acc_base;
    logic signed [ACC_W-1:0]        sum;
    logic signed [ACC_W-1:0]        shifted;
    logic [63:0]                    wide;
    logic [15:0]                    count_base;
    logic [3:0]                     eff_shift;
    logic [3:0]                     shift_use;
    logic                           accept;
    logic                           last;
    logic                           unused_wide_hi;

    assign sample     = s_axis_tdata[31 -: SAMPLE_WIDTH];
    assign sample_ext = {{MAX_LOG2_AVG{sample[SAMPLE_WIDTH-1]}}, sample};

    generate
        if (SAMPLE_WIDTH < 32) begin : g_low_bits
            logic unused_low_bits;
            assign unused_low_bits = ^s_axis_tdata[31-SAMPLE_WIDTH:0];
        end
    endgenerate

    assign s_axis_tready  = ~mvalid_q | m_axis_tready;
    assign accept         = s_axis_tvalid & s_axis_tready;
    assign eff_shift      = (log2_avg > MAX_SHIFT) ? MAX_SHIFT : log2_avg;
    assign unused_wide_hi = ^wide[63:32];

    always_comb begin
        // Clear wipes the partial block first, so a simultaneous sample opens a fresh block.
        acc_base   = clear ? '0 : acc_q;
        count_base = clear ? '0 : count_q;
        shift_use  = (count_base == 16'd0) ? eff_shift : shift_q;
        sum        = acc_base + sample_ext;
        last       = (count_base == ((16'd1 << shift_use) - 16'd1));
        shifted    = sum >>> shift_use;
        wide       = {{(64-ACC_W){shifted[ACC_W-1]}}, shifted};

        acc_d    = acc_base;
        count_d  = count_base;
        shift_d  = shift_q;
        mdata_d  = mdata_q;
        mvalid_d = mvalid_q & ~m_axis_tready;

        if (accept) begin
            shift_d = shift_use;
            if (last) begin
                // A load in the same cycle as a downstream handshake wins over the clear.
                mdata_d  = wide[31:0];
                mvalid_d = 1'b1;
                acc_d    = '0;
                count_d  = 16'd0;
            end else begin
                acc_d   = sum;
                count_d = count_base + 16'd1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc_q    <= '0;
            count_q  <= 16'd0;
            shift_q  <= 4'd0;
            mdata_q  <= 32'd0;
            mvalid_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            count_q  <= count_d;
            shift_q  <= shift_d;
            mdata_q  <= mdata_d;
            mvalid_q <= mvalid_d;
        end
    end

    assign m_axis_tdata  = mdata_q;
    assign m_axis_tvalid = mvalid_q;
    assign status        = {12'd0, shift_q, count_q};

endmodule

// File: tb/tb_adc_sample_averager.sv
// Directed bench for adc_sample_averager. Expected averages are worked out by hand,
// and every output handshake is captured in order.
module tb_adc_sample_averager;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  log2_avg = 4'd0;
    logic        clear = 1'b0;
    logic [31:0] s_tdata = 32'd0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic [31:0] status;

    int total = 0;
    int bad = 0;
    logic [31:0] outq[$];

    adc_sample_averager #(.SAMPLE_WIDTH(24), .MAX_LOG2_AVG(8)) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .log2_avg(log2_avg),
        .clear(clear),
        .s_axis_tdata(s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .status(status)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        if (aresetn && m_tvalid && m_tready)
            outq.push_back(m_tdata);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] w);
        bit   done;
        logic rdy;
        done = 1'b0;
        s_tdata  = w;
        s_tvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            #1 rdy = s_tready;
            @(posedge aclk);
            #1;
            if (rdy === 1'b1) done = 1'b1;
        end
        s_tvalid = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $error("FAIL send_timeout observed=no_accept expected=accept word=0x%08h", w);
        end
    endtask

    task automatic send_s(input int v);
        send(32'(v) << 8);
    endtask

    task automatic check_out(input string tag, input logic [31:0] exp);
        int          n;
        logic [31:0] v;
        n = 0;
        while (outq.size() == 0 && n < 20) begin
            @(posedge aclk);
            #1;
            n++;
        end
        if (outq.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=no_output expected=0x%08h", tag, exp);
        end else begin
            v = outq.pop_front();
            $display("out %s data=0x%08h", tag, v);
            check(tag, v, exp);
        end
    endtask

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_status", status, 32'h0);
        check("rst_mvalid", {31'd0, m_tvalid}, 32'h0);
        check("rst_mdata", m_tdata, 32'h0);
        check("rst_sready", {31'd0, s_tready}, 32'h1);
        tick;
        aresetn = 1'b1;
        tick;

        // 1: pass-through, back-to-back
        log2_avg = 4'd0;
        send(32'h0000_1200);
        check("t1_valid_a", {31'd0, m_tvalid}, 32'h1);
        check("t1_data_a", m_tdata, 32'h0000_0012);
        send(32'hFFFF_FF00);
        check("t1_valid_b", {31'd0, m_tvalid}, 32'h1);
        check("t1_data_b", m_tdata, 32'hFFFF_FFFF);
        check_out("t1_out_a", 32'h0000_0012);
        check_out("t1_out_b", 32'hFFFF_FFFF);

        // 2: four-sample blocks, positive and floor-negative
        log2_avg = 4'd2;
        send_s(1); send_s(2); send_s(3); send_s(5);
        check_out("t2_pos", 32'h0000_0002);
        send_s(-1); send_s(-1); send_s(-1); send_s(-2);
        check_out("t2_neg", 32'hFFFF_FFFE);

        // 3: backpressure stall
        log2_avg = 4'd1;
        m_tready = 1'b0;
        send_s(1); send_s(2);
        check("t3_pend_valid", {31'd0, m_tvalid}, 32'h1);
        check("t3_pend_data", m_tdata, 32'h0000_0001);
        s_tdata  = 32'h0000_0300;
        s_tvalid = 1'b1;
        tick; tick; tick;
        check("t3_sready_low", {31'd0, s_tready}, 32'h0);
        check("t3_hold_data", m_tdata, 32'h0000_0001);
        check("t3_hold_status", status, 32'h0001_0000);
        m_tready = 1'b1;
        send_s(3);
        for (int v = 4; v <= 8; v++) send_s(v);
        check_out("t3_out1", 32'h0000_0001);
        check_out("t3_out3", 32'h0000_0003);
        check_out("t3_out5", 32'h0000_0005);
        check_out("t3_out7", 32'h0000_0007);

        // 4: mid-block change of log2_avg
        log2_avg = 4'd2;
        send_s(1); send_s(2);
        check("t4_status_mid", status, 32'h0002_0002);
        log2_avg = 4'd0;
        send_s(3);
        check("t4_status_3", status, 32'h0002_0003);
        send_s(4);
        check_out("t4_block", 32'h0000_0002);
        check("t4_status_end", status, 32'h0002_0000);
        send_s(7);
        check("t4_status_pt", status, 32'h0000_0000);
        check_out("t4_pt_a", 32'h0000_0007);
        send_s(-128);
        check_out("t4_pt_b", 32'hFFFF_FF80);

        // 5: clear alone, then clear with accept
        log2_avg = 4'd2;
        send_s(1); send_s(2);
        clear = 1'b1;
        tick;
        clear = 1'b0;
        check("t5_clear_status", status, 32'h0002_0000);
        send_s(4); send_s(4); send_s(4); send_s(4);
        check_out("t5_fresh_a", 32'h0000_0004);
        send_s(1); send_s(2);
        clear = 1'b1;
        send_s(8);
        clear = 1'b0;
        check("t5_clracc_status", status, 32'h0002_0001);
        send_s(8); send_s(8); send_s(9);
        check_out("t5_fresh_b", 32'h0000_0008);

        // 6: full-scale 256-sample blocks, shift clamp, reset mid-block
        log2_avg = 4'd8;
        for (int i = 0; i < 256; i++) send(32'h7FFF_FF00);
        check_out("t6_max", 32'h007F_FFFF);
        log2_avg = 4'd15;
        send(32'h8000_0000);
        check("t6_clamp_status", status, 32'h0008_0001);
        for (int i = 1; i < 256; i++) send(32'h8000_0000);
        check_out("t6_min", 32'hFF80_0000);

        for (int i = 0; i < 10; i++) send_s(100);
        #2 aresetn = 1'b0;
        #1;
        check("t6_rst_status", status, 32'h0);
        check("t6_rst_valid", {31'd0, m_tvalid}, 32'h0);
        tick;
        aresetn = 1'b1;
        tick;

        log2_avg = 4'd0;
        m_tready = 1'b0;
        send(32'h0000_0900);
        check("t6_pend_data", m_tdata, 32'h0000_0009);
        #2 aresetn = 1'b0;
        #1;
        check("t6_rst_pend_valid", {31'd0, m_tvalid}, 32'h0);
        check("t6_rst_pend_data", m_tdata, 32'h0);
        tick;
        aresetn = 1'b1;
        m_tready = 1'b1;
        tick;
        log2_avg = 4'd1;
        send_s(3); send_s(6);
        check_out("t6_clean", 32'h0000_0004);
        tick; tick;
        check("no_extra_outputs", 32'(outq.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_sample_averager.md
Name: adc_sample_averager

Overview:
Streaming block directly downstream of the ADC SPI manager. Consumes 32-bit conversion words on AXI Stream, extracts the signed ADC sample, and averages blocks of 2^k consecutive samples (k runtime-selectable, 0 = pass-through). Emits one sign-extended 32-bit average per block on AXI Stream toward the DMA/FIFO path. Full backpressure, no sample is ever dropped.

Parameters:
SAMPLE_WIDTH, 24, signed sample width taken from s_axis_tdata[31:32-SAMPLE_WIDTH]; legal range 8..32.
MAX_LOG2_AVG, 8, largest supported log2 of block length; legal range 1..15.

Ports:
aclk  input  1  clock; all logic on rising edge.
aresetn  input  1  asynchronous active-low reset.
log2_avg  input  4  requested log2 of block length; sampled only at block start.
clear  input  1  synchronous; discards the partial block.
s_axis_tdata  input  32  conversion word; sample in [31:32-SAMPLE_WIDTH], the remaining low bits are ignored.
s_axis_tvalid  input  1  input word valid.
s_axis_tready  output  1  input accept.
m_axis_tdata  output  32  averaged sample, sign-extended.
m_axis_tvalid  output  1  output valid.
m_axis_tready  input  1  downstream accept.
status  output  32  [15:0] samples in current block, [19:16] active shift, [31:20] zero.

Behaviour:
- Reset (async assert, sync release): accumulator=0, count=0, active shift=0, m_axis_tdata=0, m_axis_tvalid=0, status=0. Reset mid-block discards everything, including a pending output.
- s_axis_tready = ~m_axis_tvalid | m_axis_tready (combinational). Accept = s_axis_tvalid & s_axis_tready.
- Effective shift = min(log2_avg, MAX_LOG2_AVG). It is latched into the active shift on an accept with count==0, and it governs that whole block. A change of log2_avg mid-block does not take effect until the next block.
- Accumulator width is SAMPLE_WIDTH+MAX_LOG2_AVG, signed. Each accepted sample is sign-extended to this width before it is added. Overflow is impossible by construction.
- On accept, N = 2^shift (using the shift latched this cycle when count==0):
  - If count == N-1: m_axis_tdata <= (accumulator + sample) >>> shift, i.e. arithmetic shift with floor rounding, sign-extended or truncated to 32 bits. m_axis_tvalid <= 1; accumulator <= 0; count <= 0.
  - Otherwise: accumulator <= accumulator + sample; count <= count+1.
- Latency: m_axis_tvalid rises on the first aclk edge after the accept of the Nth sample. With shift=0, every accepted word produces an output the next cycle, and throughput is 1 word/cycle under continuous m_axis_tready.
- Output register: m_axis_tvalid clears on an m handshake, unless a new result is loaded in the same cycle. Load wins and is permitted because s_axis_tready was high.
- m_axis_tdata holds stable while m_axis_tvalid=1 and m_axis_tready=0. No new accept can occur in that state.
- Clear:
  - Forces accumulator=0 and count=0. It does not touch a pending output.
  - Clear together with accept: clear takes priority over the old partial sum. The accepted sample becomes the first sample of a new block, which latches the shift. If N=1, that sample completes the block as a normal output.
- Status count reflects registered count; it never equals N.
- Backpressure stall never loses or duplicates an input word.

Test Plan:
1. log2_avg=0, input words 0x00001200 then 0xFFFFFF00, m_axis_tready=1 -> outputs 0x00000012 then 0xFFFFFFFF, each one cycle after accept, back-to-back.
2. log2_avg=2, samples 1,2,3,5 (words 0x100,0x200,0x300,0x500) -> single output 0x00000002. Samples -1,-1,-1,-2 -> 0xFFFFFFFE (floor of -1.25).
3. log2_avg=1, m_axis_tready=0 after the first result while s_axis_tvalid is held high -> s_axis_tready=0 and the output stays stable. Raising m_axis_tready resumes with no lost word; input 1..8 yields 1,3,5,7 (floor of 1.5,3.5,5.5,7.5).
4. log2_avg=2, change to 0 after 2 samples -> that block still completes after 4 samples. The next words pass through 1:1, and status[19:16] updates at the next block start.
5. log2_avg=2, 2 samples, then clear (without and with a simultaneous accept) -> status count returns to 0 or 1 respectively. The next output is the average of the fresh samples only.
6. log2_avg=8, 256×0x7FFFFF -> 0x007FFFFF; 256×0x800000 -> 0xFF800000. Assert aresetn low mid-block -> all outputs 0 and the next block starts clean.
